// File: rtl/store_dmem_rmw.sv
// Purpose : LSU store path into a word-wide dmem without byte enables; sub-word stores are read-modify-write.
// Latency : word store done at T+1 after accept; byte/half store done at T+2+MEM_RD_LAT; reject pulse at T+1.
// Backpr. : i_req_valid is accepted only in IDLE (o_req_ready=1); o_req_ready stays low until the sequence ends.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req_valid/o_req_ready store request handshake
//   i_req_addr              byte address (bits above ADDR_W+1 wrap)
//   i_req_accessmode        00 byte, 01 half, 10 word, 11 illegal
//   i_req_data              right-justified store data
//   o_done                  one-cycle pulse, store committed
//   o_misaligned            one-cycle pulse, request rejected without memory access
//   o_mem_addr/o_mem_re     dmem word address and read strobe
//   i_mem_rdata             dmem read data, valid MEM_RD_LAT cycles after o_mem_re
//   o_mem_we/o_mem_wdata    dmem full-word write strobe and data
//   o_mem_be                lanes modified by the write (trace only)

module store_dmem_rmw #(
    parameter int ADDR_W     = 10,
    parameter int MEM_RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [31:0]       i_req_addr,
    input  logic [1:0]        i_req_accessmode,
    input  logic [31:0]       i_req_data,
    output logic              o_done,
    output logic              o_misaligned,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_re,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_mem_we,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_be
);

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_WORD = 2'b10;

    // Counter only needs to hold MEM_RD_LAT-1.
    localparam int              CNT_W    = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_waddr;
    logic [1:0]          r_lane;
    logic [1:0]          r_mode;
    logic [15:0]         r_sdata;
    logic [31:0]         r_wdata;
    logic [3:0]          r_be;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_accept;
    logic                w_misalign;
    logic                w_rd_done;
    logic [3:0]          w_be_acc;
    logic [31:0]         w_merged;

    // Upper address bits are intentionally dropped so the memory wraps.
    logic                w_unused_addr;
    assign w_unused_addr = &{1'b0, i_req_addr[31:ADDR_W+2]};

    assign w_accept  = i_req_valid && (r_state == S_IDLE);
    assign w_rd_done = (r_state == S_WAIT) && (r_cnt == '0);

    always_comb begin
        w_misalign = 1'b0;
        case (i_req_accessmode)
            MODE_BYTE: w_misalign = 1'b0;
            MODE_HALF: w_misalign = i_req_addr[0];
            MODE_WORD: w_misalign = (i_req_addr[1:0] != 2'b00);
            default:   w_misalign = 1'b1;
        endcase
    end

    // Lane mask computed at accept so the write cycle only replays registers.
    always_comb begin
        w_be_acc = 4'b1111;
        case (i_req_accessmode)
            MODE_BYTE: w_be_acc = 4'b0001 << i_req_addr[1:0];
            MODE_HALF: w_be_acc = i_req_addr[1] ? 4'b1100 : 4'b0011;
            default:   w_be_acc = 4'b1111;
        endcase
    end

    // Overlay the stored byte/half onto the word just read back.
    always_comb begin
        w_merged = i_mem_rdata;
        case (r_mode)
            MODE_BYTE: w_merged[{r_lane, 3'b000} +: 8]     = r_sdata[7:0];
            MODE_HALF: w_merged[{r_lane[1], 4'b0000} +: 16] = r_sdata;
            default:   w_merged = i_mem_rdata;
        endcase
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    if (w_misalign) begin
                        w_state_nxt = S_ERR;
                    end else if (i_req_accessmode == MODE_WORD) begin
                        w_state_nxt = S_WRITE;
                    end else begin
                        w_state_nxt = S_READ;
                    end
                end
            end
            S_READ:  w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = (r_cnt == '0) ? S_WRITE : S_WAIT;
            S_WRITE: w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Strobes are gated by i_rst so a reset landing mid-RMW suppresses
    // the write in the very cycle it is asserted.
    always_comb begin
        o_req_ready  = (r_state == S_IDLE);
        o_done       = 1'b0;
        o_misaligned = 1'b0;
        o_mem_re     = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_mem_be     = '0;
        if (!i_rst) begin
            case (r_state)
                S_READ: begin
                    o_mem_re   = 1'b1;
                    o_mem_addr = r_waddr;
                end
                S_WRITE: begin
                    o_mem_we    = 1'b1;
                    o_done      = 1'b1;
                    o_mem_addr  = r_waddr;
                    o_mem_wdata = r_wdata;
                    o_mem_be    = r_be;
                end
                S_ERR: begin
                    o_misaligned = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_waddr <= '0;
            r_lane  <= '0;
            r_mode  <= '0;
            r_sdata <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_waddr <= i_req_addr[ADDR_W+1:2];
                r_lane  <= i_req_addr[1:0];
                r_mode  <= i_req_accessmode;
                r_sdata <= i_req_data[15:0];
                r_be    <= w_be_acc;
                // Word stores write this directly; sub-word stores overwrite it with the merge.
                r_wdata <= i_req_data;
            end
            if (r_state == S_READ) begin
                r_cnt <= CNT_INIT;
            end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_rd_done) begin
                r_wdata <= w_merged;
            end
        end
    end

endmodule
